exe_mem_stage_skid: RTL and testbench
=====================================

// Module: exe_mem_stage_skid
// PURPOSE
//  Parametrised EXE->MEM pipeline stage register with valid/ready handshake.
//  Carries instruction, control, ALU result and the A/B operands.
//  Optional 2-entry skid buffer keeps in_ready registered, so back-pressure from MEM
//  never forms a combinational path into EXE. Synchronous flush squashes in-flight state.
//  A saturating stall counter gives performance visibility.
// PARAMETERS
//  INSTR_W  32  instruction field width
//  CTRL_W   15  control-message width
//  DATA_W   32  width of alu, A and B
//  SKID     1   1: 2-entry skid buffer, registered in_ready; 0: single entry, combinational in_ready
//  STALL_W  16  stall counter width
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  flush      in   1        synchronous squash of all held entries
//  in_valid   in   1        EXE presents a valid payload
//  in_ready   out  1        stage accepts the payload this cycle
//  in_instr   in   INSTR_W  instruction
//  in_ctrl    in   CTRL_W   control message
//  in_alu     in   DATA_W   ALU result
//  in_a       in   DATA_W   operand A
//  in_b       in   DATA_W   operand B
//  out_valid  out  1        main entry holds a valid payload
//  out_ready  in   1        MEM consumes the payload this cycle
//  out_instr  out  INSTR_W  registered instruction
//  out_ctrl   out  CTRL_W   registered control message
//  out_alu    out  DATA_W   registered ALU result
//  out_a      out  DATA_W   registered operand A
//  out_b      out  DATA_W   registered operand B
//  stall_cnt  out  STALL_W  count of cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=EMPTY, all payload regs=0, out_valid=0, stall_cnt=0,
//    in_ready=1 (SKID=1).
//  - Transfer rules: accept = in_valid & in_ready; dequeue = out_valid & out_ready.
//    Latency from accept to out_valid is 1 cycle.
//  - States (SKID=1):
//    EMPTY: accept -> main<=in, BUSY.
//    BUSY:  accept & dequeue -> main<=in, stay BUSY.
//           accept & !dequeue -> skid<=in, FULL.
//           !accept & dequeue -> EMPTY.
//    FULL:  in_ready=0; dequeue -> main<=skid, BUSY; otherwise hold.
//  - SKID=1: in_ready is a flop, equal to (next state != FULL).
//  - SKID=0: no FULL state; in_ready = out_ready | ~out_valid (combinational).
//  - Entry order is strict FIFO. A payload is never dropped or duplicated except by flush.
//  - Payload outputs always reflect the main entry. After a dequeue with no refill, the
//    old payload is held and out_valid=0.
//  - flush=1 has top priority: next state=EMPTY, main and skid payloads=0, out_valid=0.
//    in_ready returns to 1 on the next cycle. An input accepted in the flush cycle is
//    discarded. A dequeue in the flush cycle still counts as consumed by MEM.
//    stall_cnt is not affected by flush.
//  - stall_cnt increments once per cycle with out_valid & ~out_ready. It saturates at
//    2^STALL_W-1 and never wraps.
//  - Reset asserted mid-operation clears everything immediately, independent of clk.
//  - Payload fields are independent; no field width is truncated or extended internally.
// TESTING
//  1. Stream: out_ready=1, in_valid=1 for 8 cycles, in_alu=1..8
//     -> out_alu=1..8 in order, each 1 cycle later; in_ready stays 1; stall_cnt=0.
//  2. Skid: BUSY with alu=5; drive alu=6 with out_ready=0
//     -> FULL, in_ready=0 next cycle; raise out_ready -> out 5 then 6, back to EMPTY.
//  3. Stall count: hold out_valid with out_ready=0 for 10 cycles -> stall_cnt=10.
//     With STALL_W=3, hold 12 cycles -> stall_cnt=7.
//  4. Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_alu=0, in_ready=1;
//     the flushed payloads never appear on the output.
//  5. Async reset mid-FULL, pulsed between clock edges
//     -> out_valid=0, all outputs 0, stall_cnt=0 immediately.
//  6. SKID=0 build: out_ready=0 while valid -> in_ready=0 in the same cycle;
//     a random valid/ready soak against a FIFO scoreboard shows no loss or reorder.

Source files
------------

// File: rtl/exe_mem_stage_skid.sv
// ---------------------------------------------------------------------------
// exe_mem_stage_skid
// EXE->MEM pipeline stage register with a valid/ready handshake on both sides.
// It carries the instruction, the control message, the ALU result and the A/B
// operands.
//
// With SKID=1 a two-entry skid buffer (main + skid) keeps o_in_ready a flop.
// Back-pressure from MEM therefore never reaches EXE combinationally.
// With SKID=0 the stage holds a single entry, and o_in_ready is combinational.
//
// i_flush squashes every held entry synchronously. A saturating counter
// counts the cycles in which MEM stalls a valid output.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   i_flush                 synchronous squash of all held entries
//   i_in_valid/o_in_ready   upstream handshake
//   i_in_instr/ctrl/alu/a/b upstream payload fields
//   o_out_valid/i_out_ready downstream handshake
//   o_out_instr/ctrl/alu/a/b registered payload of the main entry
//   o_stall_cnt             saturating count of cycles with valid & !ready
// ---------------------------------------------------------------------------
module exe_mem_stage_skid #(
  parameter int INSTR_W = 32,
  parameter int CTRL_W  = 15,
  parameter int DATA_W  = 32,
  parameter int SKID    = 1,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [INSTR_W-1:0] i_in_instr,
  input  logic [CTRL_W-1:0]  i_in_ctrl,
  input  logic [DATA_W-1:0]  i_in_alu,
  input  logic [DATA_W-1:0]  i_in_a,
  input  logic [DATA_W-1:0]  i_in_b,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [INSTR_W-1:0] o_out_instr,
  output logic [CTRL_W-1:0]  o_out_ctrl,
  output logic [DATA_W-1:0]  o_out_alu,
  output logic [DATA_W-1:0]  o_out_a,
  output logic [DATA_W-1:0]  o_out_b,
  output logic [STALL_W-1:0] o_stall_cnt
);

  localparam int PL_W = INSTR_W + CTRL_W + 3 * DATA_W;
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PL_W-1:0]   r_main;
  logic [PL_W-1:0]   w_main_nxt;
  logic [PL_W-1:0]   r_skid;
  logic [PL_W-1:0]   w_skid_nxt;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [STALL_W-1:0] r_stall_cnt;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_dequeue;
  logic [PL_W-1:0]   w_in_pl;

  assign w_in_pl = {i_in_instr, i_in_ctrl, i_in_alu, i_in_a, i_in_b};

  // The single-entry build may take a new payload whenever the current one leaves.
  assign w_in_ready = (SKID != 0) ? r_in_ready : (i_out_ready | ~r_out_valid);
  assign w_accept   = i_in_valid & w_in_ready;
  assign w_dequeue  = r_out_valid & i_out_ready;

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign {o_out_instr, o_out_ctrl, o_out_alu, o_out_a, o_out_b} = r_main;
  assign o_stall_cnt = r_stall_cnt;

  // Next-state and next-payload selection; flush overrides every transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_nxt  = w_in_pl;
            w_state_nxt = ST_BUSY;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (w_accept && w_dequeue) begin
            w_main_nxt = w_in_pl;
          end else if (w_accept) begin
            // Unreachable when SKID=0: in_ready there implies a dequeue.
            w_skid_nxt  = w_in_pl;
            w_state_nxt = ST_FULL;
          end else if (w_dequeue) begin
            w_state_nxt = ST_EMPTY;
          end else begin
            w_state_nxt = ST_BUSY;
          end
        end
        ST_FULL: begin
          if (w_dequeue) begin
            w_main_nxt  = r_skid;
            w_state_nxt = ST_BUSY;
          end else begin
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // State, payload and handshake flops; valid and ready come from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_in_ready  <= (w_state_nxt != ST_FULL);
    end
  end

  // Saturating stall counter; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !i_out_ready && (r_stall_cnt != STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

endmodule

// File: tb/tb_exe_mem_stage_skid.sv
// ---------------------------------------------------------------------------
// Bench for exe_mem_stage_skid. Three instances share one stimulus stream:
//   index 0: SKID=1, STALL_W=16
//   index 1: SKID=0, STALL_W=16
//   index 2: SKID=1, STALL_W=3
// Each instance is compared every cycle against a FIFO model of its contents.
// The model has a capacity of 2 or 1 and holds the last payload after a drain.
// Directed checks cover the documented scenarios.
// ---------------------------------------------------------------------------
module tb_exe_mem_stage_skid;

  typedef logic [142:0] pl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, out_ready;
  logic [31:0] in_instr, in_alu, in_a, in_b;
  logic [14:0] in_ctrl;
  pl_t         in_pl;

  logic        o_valid_a [3];
  logic        o_rdy_a   [3];
  logic [31:0] o_instr_a [3];
  logic [14:0] o_ctrl_a  [3];
  logic [31:0] o_alu_a   [3];
  logic [31:0] o_a_a     [3];
  logic [31:0] o_b_a     [3];
  logic [15:0] o_stall_a [3];
  logic [2:0]  o_stall3;

  pl_t mq [3][2];
  pl_t mheld [3];
  int  mcnt [3];
  int  mstall [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign in_pl        = {in_instr, in_ctrl, in_alu, in_a, in_b};
  assign o_stall_a[2] = {13'd0, o_stall3};

  exe_mem_stage_skid #(.SKID(1), .STALL_W(16)) u_dut_skid (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(o_rdy_a[0]),
    .i_in_instr(in_instr), .i_in_ctrl(in_ctrl), .i_in_alu(in_alu), .i_in_a(in_a), .i_in_b(in_b),
    .o_out_valid(o_valid_a[0]), .i_out_ready(out_ready), .o_out_instr(o_instr_a[0]),
    .o_out_ctrl(o_ctrl_a[0]), .o_out_alu(o_alu_a[0]), .o_out_a(o_a_a[0]), .o_out_b(o_b_a[0]),
    .o_stall_cnt(o_stall_a[0]));

  exe_mem_stage_skid #(.SKID(0), .STALL_W(16)) u_dut_single (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(o_rdy_a[1]),
    .i_in_instr(in_instr), .i_in_ctrl(in_ctrl), .i_in_alu(in_alu), .i_in_a(in_a), .i_in_b(in_b),
    .o_out_valid(o_valid_a[1]), .i_out_ready(out_ready), .o_out_instr(o_instr_a[1]),
    .o_out_ctrl(o_ctrl_a[1]), .o_out_alu(o_alu_a[1]), .o_out_a(o_a_a[1]), .o_out_b(o_b_a[1]),
    .o_stall_cnt(o_stall_a[1]));

  exe_mem_stage_skid #(.SKID(1), .STALL_W(3)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(o_rdy_a[2]),
    .i_in_instr(in_instr), .i_in_ctrl(in_ctrl), .i_in_alu(in_alu), .i_in_a(in_a), .i_in_b(in_b),
    .o_out_valid(o_valid_a[2]), .i_out_ready(out_ready), .o_out_instr(o_instr_a[2]),
    .o_out_ctrl(o_ctrl_a[2]), .o_out_alu(o_alu_a[2]), .o_out_a(o_a_a[2]), .o_out_b(o_b_a[2]),
    .o_stall_cnt(o_stall3));

  task automatic check_eq(input string tag, input pl_t obs, input pl_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pl_t dut_pl(input int k);
    return {o_instr_a[k], o_ctrl_a[k], o_alu_a[k], o_a_a[k], o_b_a[k]};
  endfunction

  function automatic int cap_of(input int k);
    return (k == 1) ? 1 : 2;
  endfunction

  function automatic int smax_of(input int k);
    return (k == 2) ? 7 : 65535;
  endfunction

  // Readiness as seen by EXE in the current cycle.
  function automatic logic m_ready(input int k);
    if (k == 1) return out_ready || (mcnt[k] == 0);
    return mcnt[k] < cap_of(k);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0; mstall[k] = 0; mheld[k] = '0; mq[k][0] = '0; mq[k][1] = '0;
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      logic deq, acc;
      deq = (mcnt[k] > 0) && out_ready;
      acc = in_valid && m_ready(k);
      if ((mcnt[k] > 0) && !out_ready && (mstall[k] < smax_of(k))) mstall[k]++;
      if (flush) begin
        mcnt[k] = 0;
        mheld[k] = '0;
      end else begin
        if (deq) begin
          mheld[k] = mq[k][0];
          mq[k][0] = mq[k][1];
          mcnt[k]--;
        end
        if (acc) begin
          mq[k][mcnt[k]] = in_pl;
          mcnt[k]++;
        end
      end
    end
  endtask

  // Compare all instances with the model, advance the model, move to next negedge.
  task automatic step();
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("d%0d_out_valid", k), pl_t'(o_valid_a[k]), pl_t'(mcnt[k] > 0));
      check_eq($sformatf("d%0d_in_ready", k), pl_t'(o_rdy_a[k]), pl_t'(m_ready(k)));
      check_eq($sformatf("d%0d_payload", k), dut_pl(k), (mcnt[k] > 0) ? mq[k][0] : mheld[k]);
      check_eq($sformatf("d%0d_stall_cnt", k), pl_t'(o_stall_a[k]), pl_t'(mstall[k]));
    end
    model_update();
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic r, input logic f, input logic [31:0] alu);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_alu    = alu;
    in_instr  = $urandom;
    in_ctrl   = 15'($urandom);
    in_a      = $urandom;
    in_b      = $urandom;
  endtask

  task automatic drive(input logic v, input logic r, input logic f, input logic [31:0] alu);
    set_in(v, r, f, alu);
    step();
  endtask

  task automatic sync_reset_pulse();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_eq("reset_in_ready", pl_t'(o_rdy_a[0]), pl_t'(1'b1));
    check_eq("reset_payload", dut_pl(0), '0);
    drive(1'b0, 1'b1, 1'b0, 32'd0);

    // Streaming: each value appears one cycle after it is offered.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(i));
      check_eq("stream_alu", pl_t'(o_alu_a[0]), pl_t'(i));
      check_eq("stream_in_ready", pl_t'(o_rdy_a[0]), pl_t'(1'b1));
    end
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("stream_stall", pl_t'(o_stall_a[0]), '0);

    // Skid fill and drain in FIFO order.
    drive(1'b1, 1'b1, 1'b0, 32'd5);
    set_in(1'b1, 1'b0, 1'b0, 32'd6);
    #1;
    check_eq("single_in_ready_comb", pl_t'(o_rdy_a[1]), pl_t'(1'b0));
    step();
    check_eq("skid_full_in_ready", pl_t'(o_rdy_a[0]), pl_t'(1'b0));
    check_eq("skid_full_alu", pl_t'(o_alu_a[0]), pl_t'(32'd5));
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("skid_drain_first", pl_t'(o_alu_a[0]), pl_t'(32'd6));
    check_eq("skid_drain_valid", pl_t'(o_valid_a[0]), pl_t'(1'b1));
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    check_eq("skid_empty_valid", pl_t'(o_valid_a[0]), pl_t'(1'b0));
    check_eq("skid_empty_held", pl_t'(o_alu_a[0]), pl_t'(32'd6));

    // Stall counting and saturation.
    sync_reset_pulse();
    drive(1'b1, 1'b0, 1'b0, 32'd9);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("stall_10", pl_t'(o_stall_a[0]), pl_t'(16'd10));
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("stall_12", pl_t'(o_stall_a[0]), pl_t'(16'd12));
    check_eq("stall_sat_w3", pl_t'(o_stall3), pl_t'(3'd7));

    // Flush while full with a new input offered.
    drive(1'b1, 1'b0, 1'b0, 32'd10);
    check_eq("pre_flush_full", pl_t'(o_rdy_a[0]), pl_t'(1'b0));
    drive(1'b1, 1'b0, 1'b1, 32'h77);
    check_eq("flush_valid", pl_t'(o_valid_a[0]), pl_t'(1'b0));
    check_eq("flush_alu", pl_t'(o_alu_a[0]), '0);
    check_eq("flush_in_ready", pl_t'(o_rdy_a[0]), pl_t'(1'b1));
    check_eq("flush_keeps_stall", pl_t'(o_stall_a[0]), pl_t'(16'd14));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 32'd0);

    // Asynchronous reset pulsed between edges while full.
    drive(1'b1, 1'b0, 1'b0, 32'd20);
    drive(1'b1, 1'b0, 1'b0, 32'd21);
    check_eq("pre_reset_full", pl_t'(o_rdy_a[0]), pl_t'(1'b0));
    set_in(1'b0, 1'b0, 1'b0, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("areset_valid", pl_t'(o_valid_a[0]), pl_t'(1'b0));
    check_eq("areset_payload", dut_pl(0), '0);
    check_eq("areset_stall", pl_t'(o_stall_a[0]), '0);
    check_eq("areset_stall_w3", pl_t'(o_stall3), '0);
    check_eq("areset_in_ready", pl_t'(o_rdy_a[0]), pl_t'(1'b1));
    model_reset();
    #1 rst_n = 1'b1;
    step();

    // Random soak with varying back-pressure density and rare flushes.
    for (int i = 0; i < 1500; i++) begin
      int rp;
      rp = (i < 500) ? 3 : ((i < 1000) ? 1 : 2);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) < rp,
             $urandom_range(0, 40) == 0, $urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
